// File: rtl/i2c_eeprom_target.sv
// i2c_eeprom_target
//   I2C target that emulates a 256-byte 24Cxx-style serial EEPROM for
//   programmer self-test and loopback. Storage lives in an external
//   synchronous byte memory; SCL/SDA are oversampled on the system clock
//   and SDA is only ever pulled low (open drain).
//
//   Optional feature macro: I2C_EEPROM_TARGET_GLITCH_FILTER_EN
//     defined   -> 3-sample stability filter on synchronized SCL/SDA
//                  (pulses of 2 clocks or fewer ignored, 5-clock latency)
//     undefined -> plain 2-FF synchronizers (3-clock latency)
module i2c_eeprom_target #(
    parameter logic [3:0]  DEV_TYPE = 4'b1010,
    parameter int unsigned MEM_AW   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    input  logic [2:0]        chip_sel,
    input  logic              wc_n,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEVADDR,
        ST_WADDR,
        ST_WDATA,
        ST_ACK_SETUP,   // 8th bit taken, waiting for SCL fall to open the ACK slot
        ST_ACK,         // ACK slot open, waiting for SCL fall to close it
        ST_RDATA,
        ST_RACK         // initiator's acknowledge of a read byte
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_lvl, scl_last, sda_lvl, sda_last;

    // Two-stage synchronizers for the asynchronous bus lines.
    // NOTE: synchronizers reset to 1 (idle bus level) so leaving reset never
    // fabricates a falling SDA edge that would look like a START.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end

`ifdef I2C_EEPROM_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;
    logic       scl_filt_d, sda_filt_d;

    // Accept a new level only once three successive synchronized samples agree.
    always_comb begin
        scl_filt_d = scl_filt_q;
        sda_filt_d = sda_filt_q;
        if (scl_sync_q[1] == scl_hist_q[0] && scl_hist_q[0] == scl_hist_q[1])
            scl_filt_d = scl_hist_q[0];
        if (sda_sync_q[1] == sda_hist_q[0] && sda_hist_q[0] == sda_hist_q[1])
            sda_filt_d = sda_hist_q[0];
    end

    // Sample history and accepted level; the accepted level doubles as the
    // delayed copy used for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_lvl  = scl_filt_d;
    assign scl_last = scl_filt_q;
    assign sda_lvl  = sda_filt_d;
    assign sda_last = sda_filt_q;
`else
    logic scl_prev_q, sda_prev_q;

    // One-clock delayed copy of the synchronized lines for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_lvl  = scl_sync_q[1];
    assign scl_last = scl_prev_q;
    assign sda_lvl  = sda_sync_q[1];
    assign sda_last = sda_prev_q;
`endif

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = scl_lvl & ~scl_last;
    assign scl_fall  = ~scl_lvl & scl_last;
    assign start_det = scl_lvl & scl_last & sda_last & ~sda_lvl;
    assign stop_det  = scl_lvl & scl_last & ~sda_last & sda_lvl;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d, after_q, after_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d;
    logic              ack_q, ack_d;
    logic              sda_oe_q, sda_oe_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    logic [7:0] rx_byte;
    logic       dev_match;

    assign rx_byte   = {shift_q[6:0], sda_lvl};
    assign dev_match = (rx_byte[7:4] == DEV_TYPE) && (rx_byte[3:1] == chip_sel);

    // Next-state and output logic; START/STOP override all bit processing.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        after_d     = after_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        ack_d       = ack_q;
        sda_oe_d    = sda_oe_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;

        // The pointer advances the clock after the write strobe, so the
        // strobe is presented together with the address it targets.
        if (mem_we_q)
            ptr_d = ptr_q + MEM_AW'(1);

        if (start_det) begin
            state_d  = ST_DEVADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;

                ST_DEVADDR: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (dev_match) begin
                            busy_d  = 1'b1;
                            ack_d   = 1'b1;
                            after_d = rx_byte[0] ? ST_RDATA : ST_WADDR;
                            state_d = ST_ACK_SETUP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end

                ST_WADDR: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        ptr_d   = MEM_AW'(rx_byte);
                        ack_d   = 1'b1;
                        after_d = ST_WDATA;
                        state_d = ST_ACK_SETUP;
                    end
                end

                ST_WDATA: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        ack_d   = ~wc_n;
                        after_d = ST_WDATA;
                        state_d = ST_ACK_SETUP;
                        if (!wc_n) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = rx_byte;
                        end
                    end
                end

                ST_ACK_SETUP: if (scl_fall) begin
                    sda_oe_d = ack_q;
                    state_d  = ST_ACK;
                end

                // Closing the ACK slot; entering a read loads and presents
                // the first data bit on this same falling edge.
                ST_ACK: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = after_q;
                    if (after_q == ST_RDATA) begin
                        shift_d  = mem_rdata;
                        ptr_d    = ptr_q + MEM_AW'(1);
                        sda_oe_d = ~mem_rdata[7];
                    end
                end

                ST_RDATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7)
                            state_d = ST_RACK;
                    end else if (scl_fall) begin
                        sda_oe_d = ~shift_q[7];
                    end
                end

                ST_RACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        if (!sda_lvl) begin
                            after_d = ST_RDATA;
                            state_d = ST_ACK;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            after_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            ack_q       <= 1'b0;
            sda_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            after_q     <= after_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            ack_q       <= ack_d;
            sda_oe_q    <= sda_oe_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign mem_addr  = ptr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// tb_i2c_eeprom_target
//   Bench-side I2C initiator, open-drain SDA wiring and an external byte
//   memory for i2c_eeprom_target. Write-type transactions come from a
//   vector table; random read and reset-during-read are hand sequences.
//   Expected memory writes and read bytes flow through scoreboard queues.
module tb_i2c_eeprom_target;

    localparam int Q = 4;   // clocks per quarter SCL period (SCL = clock/16)

    logic       clock;
    logic       reset;
    logic       scl_drv, sda_drv;
    logic       sda_line;
    logic       sda_oe;
    logic [2:0] cs;
    logic       wc;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;
    logic       busy;

    assign sda_line = sda_drv & ~sda_oe;

    i2c_eeprom_target dut (
        .clock     (clock),
        .reset     (reset),
        .scl_in    (scl_drv),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .chip_sel  (cs),
        .wc_n      (wc),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // External memory: one-clock read latency, plus a bench preload port.
    logic [7:0] mem_model [256];
    logic       pre_we;
    logic [7:0] pre_addr, pre_data;

    always @(posedge clock) begin
        if (pre_we)
            mem_model[pre_addr] <= pre_data;
        else if (mem_we)
            mem_model[mem_addr] <= mem_wdata;
        mem_rdata <= mem_model[mem_addr];
    end

    // Scoreboards.
    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wr_q [$];
    wr_t        exp_w;
    logic [7:0] rd_q [$];

    int oe_hits   = 0;
    int busy_hits = 0;

    // Write monitor: each strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (sda_oe) oe_hits++;
        if (busy)   busy_hits++;
        if (!reset && mem_we) begin
            check("mem_we_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                exp_w = wr_q.pop_front();
                check("mem_we_addr", 32'(mem_addr), 32'(exp_w.addr));
                check("mem_we_data", 32'(mem_wdata), 32'(exp_w.data));
            end
        end
    end

    // ---------------- bus primitives ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick(1);
        pre_we   = 1'b0;
    endtask

    task automatic bus_start();
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic bus_rstart();
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b1; tick(2 * Q);
    endtask

    task automatic clock_bit(input logic b, output logic seen, output logic oe_mid);
        sda_drv = b;    tick(Q);
        scl_drv = 1'b1; tick(Q);
        seen    = sda_line;
        oe_mid  = sda_oe;
        tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s, o;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s, o);
        clock_bit(1'b1, s, o);
        acked = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b, output logic oe_ack);
        logic s, o;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s, o);
            b = {b[6:0], s};
        end
        clock_bit(~ack, s, o);
        oe_ack = o;
    endtask

    // ---------------- write-type vector table ----------------
    typedef struct {
        logic [2:0] cs;
        logic       wc_n;
        logic [7:0] dev;
        logic [7:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nbytes;
        logic       exp_dev_ack;
        logic       exp_addr_ack;
        logic       exp_data_ack;
        logic [7:0] exp_ptr;
    } wvec_t;

    localparam int NV = 6;
    wvec_t vecs [NV];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic       ack, oe_a;
        logic [7:0] d, rb;
        int         oe0, bz0;

        // cs  wc  dev    addr   d0     d1   n  devA addrA dataA ptr
        vecs[0] = '{3'd0, 1'b0, 8'hA0, 8'h10, 8'h55, 8'hAA, 2, 1'b1, 1'b1, 1'b1, 8'h12};
        vecs[1] = '{3'd0, 1'b1, 8'hA0, 8'h20, 8'h77, 8'h00, 1, 1'b1, 1'b1, 1'b0, 8'h20};
        vecs[2] = '{3'd0, 1'b0, 8'hA0, 8'hFF, 8'h11, 8'h22, 2, 1'b1, 1'b1, 1'b1, 8'h01};
        vecs[3] = '{3'd5, 1'b0, 8'hAA, 8'h40, 8'h5A, 8'h00, 1, 1'b1, 1'b1, 1'b1, 8'h41};
        vecs[4] = '{3'd0, 1'b0, 8'hA2, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h41};
        vecs[5] = '{3'd0, 1'b0, 8'hB0, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h41};

        reset   = 1'b1;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        cs      = 3'd0;
        wc      = 1'b0;
        pre_we  = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        tick(3);

        check("rst_sda_oe",    32'(sda_oe),    32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);

        reset = 1'b0;
        tick(4);

        for (int v = 0; v < NV; v++) begin
            cs  = vecs[v].cs;
            wc  = vecs[v].wc_n;
            oe0 = oe_hits;
            bz0 = busy_hits;
            bus_start();
            write_byte(vecs[v].dev, ack);
            check($sformatf("v%0d_dev_ack", v), 32'(ack), 32'(vecs[v].exp_dev_ack));
            if (vecs[v].exp_dev_ack) begin
                check($sformatf("v%0d_busy_mid", v), 32'(busy), 32'd1);
                write_byte(vecs[v].addr, ack);
                check($sformatf("v%0d_addr_ack", v), 32'(ack), 32'(vecs[v].exp_addr_ack));
                for (int k = 0; k < vecs[v].nbytes; k++) begin
                    d = (k == 0) ? vecs[v].d0 : vecs[v].d1;
                    if (vecs[v].exp_data_ack)
                        wr_q.push_back('{addr: vecs[v].addr + 8'(k), data: d});
                    write_byte(d, ack);
                    check($sformatf("v%0d_data%0d_ack", v, k), 32'(ack), 32'(vecs[v].exp_data_ack));
                end
            end
            bus_stop();
            tick(4);
            check($sformatf("v%0d_busy_after_stop", v), 32'(busy), 32'd0);
            check($sformatf("v%0d_ptr", v), 32'(mem_addr), 32'(vecs[v].exp_ptr));
            check($sformatf("v%0d_wr_sb_empty", v), 32'(wr_q.size()), 32'd0);
            if (!vecs[v].exp_dev_ack) begin
                check($sformatf("v%0d_no_oe", v),   32'(oe_hits - oe0),   32'd0);
                check($sformatf("v%0d_no_busy", v), 32'(busy_hits - bz0), 32'd0);
            end
        end

        // Random read: set address 0x10, repeated START, read two bytes.
        cs = 3'd0;
        wc = 1'b0;
        poke(8'h10, 8'h3C);
        poke(8'h11, 8'hC3);
        rd_q.push_back(8'h3C);
        rd_q.push_back(8'hC3);
        bus_start();
        write_byte(8'hA0, ack); check("rr_dev_w_ack", 32'(ack), 32'd1);
        write_byte(8'h10, ack); check("rr_addr_ack",  32'(ack), 32'd1);
        bus_rstart();
        write_byte(8'hA1, ack); check("rr_dev_r_ack", 32'(ack), 32'd1);
        read_byte(1'b1, rb, oe_a);
        check("rr_byte0", 32'(rb), 32'(rd_q.pop_front()));
        check("rr_oe_in_ack0", 32'(oe_a), 32'd0);
        read_byte(1'b0, rb, oe_a);
        check("rr_byte1", 32'(rb), 32'(rd_q.pop_front()));
        check("rr_oe_in_ack1", 32'(oe_a), 32'd0);
        tick(Q);
        check("rr_busy_after_nack", 32'(busy), 32'd1);
        check("rr_oe_after_nack", 32'(sda_oe), 32'd0);
        bus_stop();
        tick(4);
        check("rr_busy_after_stop", 32'(busy), 32'd0);
        check("rr_ptr", 32'(mem_addr), 32'h12);

        // Reset while the target pulls SDA low for a read data bit.
        poke(8'h12, 8'h0F);
        poke(8'h00, 8'h96);
        bus_start();
        write_byte(8'hA1, ack); check("rst_rd_dev_ack", 32'(ack), 32'd1);
        check("rst_rd_oe_bit7", 32'(sda_oe), 32'd1);
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(2);
        check("rst_rd_oe_scl_high", 32'(sda_oe), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_oe",   32'(sda_oe),   32'd0);
        check("rst_async_ptr",  32'(mem_addr), 32'd0);
        check("rst_async_busy", 32'(busy),     32'd0);
        @(negedge clock);
        tick(2);
        reset = 1'b0;
        tick(4);
        rd_q.push_back(8'h96);
        bus_start();
        write_byte(8'hA1, ack); check("post_rst_dev_ack", 32'(ack), 32'd1);
        read_byte(1'b0, rb, oe_a);
        check("post_rst_byte", 32'(rb), 32'(rd_q.pop_front()));
        bus_stop();
        tick(4);
        check("post_rst_ptr",  32'(mem_addr), 32'h01);
        check("post_rst_busy", 32'(busy),     32'd0);
        check("final_wr_sb_empty", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
